dct_stage2_rdout: RTL and testbench

Read-side companion to the stage-2 DCT flip-flop bank. It takes a snapshot of a complete 8x8 coefficient block from the bank, releases the bank for the next block, and streams the 64 coefficients one per beat over a valid/ready interface to the quantizer. Scan order is fixed column-major raster by default, or JPEG zigzag when the optional feature is compiled in.

---
 rtl/dct_stage2_rdout.sv | 128 ++++++++++++
 tb/tb_dct_stage2_rdout.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dct_stage2_rdout.sv
// dct_stage2_rdout
// Read-side companion to the stage-2 DCT flip-flop bank. Snapshots a full
// 8x8 coefficient block, acknowledges the bank so it can be refilled, and
// streams the 64 coefficients one per beat over valid/ready.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active low
//   blk_valid  bank holds a complete block (held until blk_ack)
//   data_in    bank contents, data_in[col][row], SIZE bits each
//   blk_ack    one-cycle pulse: snapshot taken, bank may be overwritten
//   out_data   current coefficient
//   out_row    row index of out_data
//   out_col    column index of out_data
//   out_last   high on the 64th beat of a block
//   out_valid  out_* fields are valid
//   out_ready  downstream accepts the beat
//
// Build option: DCT_RDOUT_ZIGZAG_EN selects JPEG zigzag scan order;
// without it the scan is column-major raster and no table is built.
//
// state  | meaning
// IDLE   | no block held, waiting for blk_valid
// STREAM | snapshot held, presenting beat k (0..63)

module dct_stage2_rdout #(
    parameter int SIZE = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         blk_valid,
    input  logic [7:0][7:0][SIZE-1:0]    data_in,
    output logic                         blk_ack,
    output logic signed [SIZE-1:0]       out_data,
    output logic [2:0]                   out_row,
    output logic [2:0]                   out_col,
    output logic                         out_last,
    output logic                         out_valid,
    input  logic                         out_ready
);

    typedef enum logic {ST_IDLE, ST_STREAM} state_t;

    state_t                      state;
    logic [7:0][7:0][SIZE-1:0]   snap;
    logic [5:0]                  beat;

    logic                        capture;
    logic                        advance;
    logic [5:0]                  nxt_beat;
    logic [5:0]                  nxt_pos;
    logic [2:0]                  nxt_row;
    logic [2:0]                  nxt_col;
    logic [SIZE-1:0]             nxt_data;

`ifdef DCT_RDOUT_ZIGZAG_EN
    // Entry k is {row, col} of zigzag beat k, i.e. row*8 + col.
    localparam logic [5:0] ZZ_POS [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    function automatic logic [5:0] scan_pos(input logic [5:0] idx);
        return ZZ_POS[idx];
    endfunction
`else
    // Column-major raster: col = k[5:3], row = k[2:0]; returned as {row, col}.
    function automatic logic [5:0] scan_pos(input logic [5:0] idx);
        return {idx[2:0], idx[5:3]};
    endfunction
`endif

    // A new block is taken either from idle or on the very edge the last
    // beat leaves, which keeps back-to-back blocks bubble-free.
    always_comb begin
        capture  = blk_valid && ((state == ST_IDLE) || (out_ready && beat == 6'd63));
        advance  = (state == ST_STREAM) && out_ready && (beat != 6'd63);
        nxt_beat = capture ? 6'd0 : beat + 6'd1;
        nxt_pos  = scan_pos(nxt_beat);
        nxt_row  = nxt_pos[5:3];
        nxt_col  = nxt_pos[2:0];
        // On capture the snapshot is not loaded yet, so beat 0 comes straight from the bank.
        nxt_data = capture ? data_in[nxt_col][nxt_row] : snap[nxt_col][nxt_row];
    end

    always_ff @(posedge clk) begin
        if (capture && rst)
            snap <= data_in;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            blk_ack   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_row   <= 3'd0;
            out_col   <= 3'd0;
            beat      <= 6'd0;
        end else begin
            blk_ack <= capture;
            if (capture) begin
                state     <= ST_STREAM;
                out_valid <= 1'b1;
                out_last  <= 1'b0;
                beat      <= 6'd0;
                out_data  <= nxt_data;
                out_row   <= nxt_row;
                out_col   <= nxt_col;
            end else if (advance) begin
                beat     <= nxt_beat;
                out_last <= (nxt_beat == 6'd63);
                out_data <= nxt_data;
                out_row  <= nxt_row;
                out_col  <= nxt_col;
            end else if (state == ST_STREAM && out_ready) begin
                state     <= ST_IDLE;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                beat      <= 6'd0;
            end
        end
    end

endmodule

// File: tb/tb_dct_stage2_rdout.sv
// Bench for dct_stage2_rdout (SIZE = 8). Expected beats come from a scan
// order list built from diagonal walks (zigzag) or plain k/8, k%8 (raster),
// applied to the block the bench drove when the acknowledge came back.

module tb_dct_stage2_rdout;

    localparam int SIZE = 8;

    logic                       clk = 1'b0;
    logic                       rst = 1'b0;
    logic                       blk_valid = 1'b0;
    logic                       out_ready = 1'b0;
    logic [7:0][7:0][SIZE-1:0]  data_in = '0;
    logic                       blk_ack;
    logic [SIZE-1:0]            out_data;
    logic [2:0]                 out_row;
    logic [2:0]                 out_col;
    logic                       out_last;
    logic                       out_valid;

    typedef struct {
        logic [SIZE-1:0] data;
        int              row;
        int              col;
        bit              last;
    } beat_t;

    beat_t exp_q[$];
    int    ord_row [64];
    int    ord_col [64];
    int    n_checks = 0;
    int    n_fail = 0;
    int    gap;

    dct_stage2_rdout #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .blk_valid (blk_valid),
        .data_in   (data_in),
        .blk_ack   (blk_ack),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic void build_order();
`ifdef DCT_RDOUT_ZIGZAG_EN
        int n = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin
                    ord_row[n] = r; ord_col[n] = s - r; n++;
                end
            end else begin
                for (int r = lo; r <= hi; r++) begin
                    ord_row[n] = r; ord_col[n] = s - r; n++;
                end
            end
        end
`else
        for (int k = 0; k < 64; k++) begin
            ord_col[k] = k / 8;
            ord_row[k] = k % 8;
        end
`endif
    endfunction

    task automatic gen_block(input bit ramp);
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 8; r++)
                data_in[c][r] = ramp ? SIZE'(8 * c + r) : SIZE'($urandom);
    endtask

    // Streams nblocks blocks; abort_after > 0 stops once that many beats
    // have transferred, leaving the block in flight.
    task automatic run(input int nblocks, input int ready_pct, input bit ramp,
                       input int abort_after, output int ack_gap);
        int    acked = 0;
        int    cycles = 0;
        int    xfers = 0;
        int    last_ack = -1;
        bit    ack_next;
        beat_t b;
        ack_gap   = 0;
        gen_block(ramp);
        blk_valid = 1'b1;
        out_ready = ($urandom_range(99) < ready_pct);
        ack_next  = (exp_q.size() == 0);
        while (1) begin
            @(posedge clk); #1;
            cycles++;
            check("blk_ack", blk_ack, ack_next);
            if (blk_ack) begin
                if (last_ack >= 0) ack_gap = cycles - last_ack;
                last_ack = cycles;
                for (int k = 0; k < 64; k++) begin
                    b.row  = ord_row[k];
                    b.col  = ord_col[k];
                    b.data = data_in[ord_col[k]][ord_row[k]];
                    b.last = (k == 63);
                    exp_q.push_back(b);
                end
                acked++;
                if (acked < nblocks) gen_block(1'b0);
                else blk_valid = 1'b0;
            end
            check("out_valid", out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                b = exp_q[0];
                check("out_data", out_data, b.data);
                check("out_row", out_row, b.row);
                check("out_col", out_col, b.col);
                check("out_last", out_last, b.last);
            end
            if (abort_after > 0 && xfers == abort_after) break;
            if (acked == nblocks && exp_q.size() == 0) break;
            if (cycles > 3000) begin
                check("timeout", cycles, 0);
                break;
            end
            out_ready = ($urandom_range(99) < ready_pct);
            ack_next  = blk_valid && (exp_q.size() == 0 || (exp_q.size() == 1 && out_ready));
            if (out_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                xfers++;
            end
        end
        if (abort_after == 0) check("xfer_count", xfers, 64 * nblocks);
    endtask

    initial begin
        build_order();
        gen_block(1'b1);
        rst       = 1'b0;
        blk_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rst_valid", out_valid, 0);
            check("rst_ack", blk_ack, 0);
            check("rst_data", out_data, 0);
            check("rst_row", out_row, 0);
            check("rst_col", out_col, 0);
            check("rst_last", out_last, 0);
        end
        rst = 1'b1;

        // Ramp block, full throughput
        run(1, 100, 1'b1, 0, gap);
        // Random data with backpressure
        run(1, 50, 1'b0, 0, gap);
        run(2, 50, 1'b0, 0, gap);
        // Back-to-back blocks, blk_valid held high
        run(2, 100, 1'b0, 0, gap);
        check("ack_gap", gap, 64);
        // Reset in the middle of a block
        run(1, 100, 1'b1, 21, gap);
        rst       = 1'b0;
        blk_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_valid", out_valid, 0);
        check("abort_ack", blk_ack, 0);
        exp_q.delete();
        rst = 1'b1;
        @(posedge clk); #1;
        check("idle_ack", blk_ack, 0);
        run(1, 70, 1'b1, 0, gap);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
